// File: rtl/cube_sum_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : cube_sum_acc_if
//  Brief    : Cube input stream and sum result handshake bundle.
//  Revision : 1.0
// ============================================================================
interface cube_sum_acc_if #(
    parameter int CW = 12,
    parameter int LW = 4,
    parameter int SW = CW + LW
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] cube_in;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum_out;
    logic [LW-1:0] count_out;

    modport master (
        output in_valid, cube_in, out_ready,
        input  in_ready, out_valid, sum_out, count_out
    );

    modport slave (
        input  in_valid, cube_in, out_ready,
        output in_ready, out_valid, sum_out, count_out
    );
endinterface
`default_nettype wire

// File: rtl/cube_sum_acc.sv
`default_nettype none
// ============================================================================
//  Module   : cube_sum_acc
//  Brief    : Accumulates a run of len cube values and hands back their sum.
//  Revision : 1.0
// ============================================================================
module cube_sum_acc #(
    parameter int N  = 4,
    parameter int CW = 3 * N,
    parameter int LW = 4,
    parameter int SW = CW + LW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire logic [LW-1:0] len,
    input  wire logic          clear,
    output logic               busy,
    cube_sum_acc_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_sum,   w_sum_nxt;
    logic [LW-1:0] r_count, w_count_nxt;
    logic [LW-1:0] r_len,   w_len_nxt;
    logic [LW-1:0] w_count_inc;

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_count <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_count <= w_count_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_count_nxt = r_count;
        w_len_nxt   = r_len;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_sum_nxt   = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_sum_nxt   = '0;
                        w_count_nxt = '0;
                        if (len != '0) begin
                            w_len_nxt   = len;
                            w_state_nxt = S_ACCUM;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        w_sum_nxt   = r_sum + {{(SW-CW){1'b0}}, bus.cube_in};
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == r_len) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Every output comes straight from a register or a decode of r_state.
    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sum_out   = r_sum;
    assign bus.count_out = r_count;
    assign busy          = (r_state != S_IDLE);
endmodule
`default_nettype wire
